// File: rtl/regfile_dump_unit.sv
// Register-file dump engine: stalls the core, reads x0..x(NUM_REGS-1) over a debug read port and streams them out.
// Optional checksum beat after the last register when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_unit #(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int IDX_W        = 5,
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dump_req,
    input  logic             cpu_quiesce,
    output logic             cpu_stall,
    output logic [IDX_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [XLEN-1:0]  dump_data,
    output logic [IDX_W-1:0] dump_idx,
    output logic             dump_last,
    output logic             dump_chk,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STALL,
        S_READ,
        S_PRESENT,
`ifdef REGDUMP_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [XLEN-1:0]  data_q;
    logic [IDX_W-1:0] beat_idx_q;
    logic             last_q;
    logic             capture;
    logic [XLEN-1:0]  cap_word;

`ifdef REGDUMP_CHECKSUM_EN
    logic             load_chk;
    logic             chk_q;
    logic [XLEN-1:0]  sum_q;
`endif

    // The read address follows the index the FSM is about to use, so a
    // one-cycle regfile has its data ready by the time READ captures it,
    // and a zero-latency regfile can be captured in the same cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        load_chk = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (dump_req) state_d = S_STALL;
            end
            S_STALL: begin
                idx_d = '0;
                if (cpu_quiesce) begin
                    if (READ_LATENCY == 0) begin
                        capture = 1'b1;
                        state_d = S_PRESENT;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                capture = 1'b1;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
                        load_chk = 1'b1;
                        state_d  = S_CHK;
`else
                        state_d  = S_DONE;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        if (READ_LATENCY == 0) begin
                            capture = 1'b1;
                            state_d = S_PRESENT;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            S_CHK: begin
                if (dump_ready) state_d = S_DONE;
            end
`endif
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // x0 is hardwired to zero architecturally, so never trust the port for it
    assign cap_word = (idx_d == '0) ? '0 : rf_rdata;
    assign rf_raddr = idx_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q     <= '0;
            beat_idx_q <= '0;
            last_q     <= 1'b0;
        end else if (capture) begin
            data_q     <= cap_word;
            beat_idx_q <= idx_d;
`ifdef REGDUMP_CHECKSUM_EN
            last_q     <= 1'b0;
        end else if (load_chk) begin
            data_q     <= sum_q;
            beat_idx_q <= '0;
            last_q     <= 1'b1;
`else
            last_q     <= (idx_d == LAST_IDX);
`endif
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    // Sum accumulates as each word is captured, so it already includes the final register when CHK loads it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
            chk_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && dump_req) sum_q <= '0;
            else if (capture)                  sum_q <= sum_q + cap_word;
            if (capture)       chk_q <= 1'b0;
            else if (load_chk) chk_q <= 1'b1;
        end
    end
    assign dump_chk   = chk_q;
    assign dump_valid = (state_q == S_PRESENT) || (state_q == S_CHK);
`else
    assign dump_chk   = 1'b0;
    assign dump_valid = (state_q == S_PRESENT);
`endif

    assign dump_data = data_q;
    assign dump_idx  = beat_idx_q;
    assign dump_last = last_q;
    assign cpu_stall = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule
